// File: rtl/key_ctrl_pkg.sv
// Shared types for the keystroke command scheduler.
// Key count, command width, FSM states and a priority helper.
package key_ctrl_pkg;

  localparam int NUM_KEYS = 12;
  localparam int CMD_W    = 4;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  // Highest set index wins; zero when mask is empty.
  function automatic logic [CMD_W-1:0] top_idx(
    input logic [NUM_KEYS-1:0] m
  );
    logic [CMD_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (m[i]) r = CMD_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop sync, debounce counter, stable level, press pulse.
// Ports: clk, rst, key_in (raw) -> level (debounced), press (1 cycle).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_in};
      press <= 1'b0;
      if (sync[1] != level) begin
        // Final count of a stable run flips the level.
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt   <= '0;
          level <= sync[1];
          press <= sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Debounced keys -> pending mask -> fixed-priority single-command issue.
// Ports: clk_raw, rst, keystroke, cmd_ready / cmd_valid, cmd_code, key_level, pending, drop_cnt.
module key_cmd_scheduler
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DROP_W          = 8
) (
  input  logic                clk_raw,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keystroke,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [CMD_W-1:0]    cmd_code,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] pending,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int DSW = DROP_W + 5;

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] clr;
  logic [NUM_KEYS-1:0] drops;
  logic [NUM_KEYS-1:0] pend_d;
  logic [DSW-1:0]      dsum;
  logic [DROP_W-1:0]   drop_d;
  logic [CMD_W-1:0]    code_d;
  state_t              state, state_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk_raw),
      .rst   (rst),
      .key_in(keystroke[k]),
      .level (key_level[k]),
      .press (press[k])
    );
  end

  assign cmd_valid = (state == ISSUE);

  always_comb begin
    state_d = state;
    code_d  = cmd_code;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          state_d = ISSUE;
          code_d  = top_idx(pending);
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = IDLE;
          clr     = NUM_KEYS'(1) << cmd_code;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A press on a bit being cleared this cycle re-arms it, not a drop.
  always_comb begin
    drops  = press & pending & ~clr;
    pend_d = (pending & ~clr) | press;
    dsum   = DSW'(drop_cnt) + DSW'($countones(drops));
    drop_d = (|dsum[DSW-1:DROP_W]) ? '1 : dsum[DROP_W-1:0];
  end

  always_ff @(posedge clk_raw) begin
    if (rst) begin
      state    <= IDLE;
      cmd_code <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_d;
      cmd_code <= code_d;
      pending  <= pend_d;
      drop_cnt <= drop_d;
    end
  end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Self-checking bench for key_cmd_scheduler.
// Issued codes are checked against a queue of expected commands.
module tb_key_cmd_scheduler;
  import key_ctrl_pkg::*;

  logic                clk_raw = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_KEYS-1:0] keystroke = '0;
  logic                cmd_ready = 1'b0;
  logic                cmd_valid;
  logic [CMD_W-1:0]    cmd_code;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] pending;
  logic [7:0]          drop_cnt;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  key_cmd_scheduler dut (
    .clk_raw  (clk_raw),
    .rst      (rst),
    .keystroke(keystroke),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .key_level(key_level),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_raw = ~clk_raw;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_raw);
    #1;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!cmd_valid && n < lim) begin
      tick(1);
      n++;
    end
    if (!cmd_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  always @(negedge clk_raw) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_issue", cmd_code, 99);
      else chk("issue", cmd_code, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    int ok;

    tick(1);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_level", key_level, 0);
    chk("rst_pend", pending, 0);
    chk("rst_drop", drop_cnt, 0);

    // two keys held from reset release, core always ready
    rst = 1'b0;
    keystroke = 12'h082;
    cmd_ready = 1'b1;
    exp_q.push_back(7);
    exp_q.push_back(1);
    tick(5);
    chk("t1_level_e5", key_level, 0);
    tick(1);
    chk("t1_level_e6", key_level, 12'h082);
    tick(1);
    chk("t1_pend_e7", pending, 12'h082);
    chk("t1_valid_e7", cmd_valid, 0);
    tick(1);
    chk("t1_valid_e8", cmd_valid, 1);
    chk("t1_code_e8", cmd_code, 7);
    tick(1);
    chk("t1_valid_e9", cmd_valid, 0);
    chk("t1_pend_e9", pending, 12'h002);
    tick(1);
    chk("t1_valid_e10", cmd_valid, 1);
    chk("t1_code_e10", cmd_code, 1);
    tick(1);
    chk("t1_valid_e11", cmd_valid, 0);
    chk("t1_pend_e11", pending, 0);
    keystroke = '0;
    tick(8);
    chk("t1_release", key_level, 0);

    // short glitch is filtered
    keystroke = 12'h100;
    tick(2);
    keystroke = '0;
    ok = 0;
    repeat (12) begin
      tick(1);
      if (key_level[8] || pending[8] || cmd_valid) ok = 1;
    end
    chk("t2_glitch", ok, 0);

    // stall, re-press same key -> drop
    cmd_ready = 1'b0;
    keystroke = 12'h200;
    exp_q.push_back(9);
    wait_valid(20, n);
    chk("t3_code", cmd_code, 9);
    ok = 1;
    keystroke = '0;
    repeat (8) begin
      tick(1);
      if (!cmd_valid || cmd_code != 4'd9) ok = 0;
    end
    keystroke = 12'h200;
    repeat (8) begin
      tick(1);
      if (!cmd_valid || cmd_code != 4'd9) ok = 0;
    end
    chk("t3_stable", ok, 1);
    chk("t3_drop", drop_cnt, 1);
    cmd_ready = 1'b1;
    tick(1);
    chk("t3_done_valid", cmd_valid, 0);
    chk("t3_done_pend", pending, 0);
    tick(3);
    chk("t3_single", cmd_valid, 0);
    keystroke = '0;
    cmd_ready = 1'b0;
    tick(8);

    // no preemption while issuing
    keystroke = 12'h008;
    exp_q.push_back(3);
    wait_valid(20, n);
    chk("t4_first", cmd_code, 3);
    keystroke = 12'h808;
    exp_q.push_back(11);
    tick(8);
    chk("t4_pend", pending, 12'h808);
    chk("t4_hold", cmd_code, 3);
    cmd_ready = 1'b1;
    tick(1);
    chk("t4_gap", cmd_valid, 0);
    tick(1);
    chk("t4_second_v", cmd_valid, 1);
    chk("t4_second_c", cmd_code, 11);
    tick(1);
    chk("t4_end", cmd_valid, 0);
    keystroke = '0;
    cmd_ready = 1'b0;
    tick(8);

    // reset mid-issue with key held
    keystroke = 12'h020;
    wait_valid(20, n);
    chk("t5_pre", cmd_code, 5);
    rst = 1'b1;
    tick(1);
    chk("t5_valid", cmd_valid, 0);
    chk("t5_code", cmd_code, 0);
    chk("t5_level", key_level, 0);
    chk("t5_pend", pending, 0);
    chk("t5_drop", drop_cnt, 0);
    rst = 1'b0;
    exp_q.push_back(5);
    wait_valid(20, n);
    chk("t5_latency", n, 8);
    chk("t5_recode", cmd_code, 5);
    cmd_ready = 1'b1;
    tick(1);
    keystroke = '0;
    cmd_ready = 1'b0;
    tick(8);

    // drop counter saturation
    keystroke = 12'h001;
    exp_q.push_back(0);
    wait_valid(20, n);
    for (int i = 0; i < 300; i++) begin
      keystroke = '0;
      tick(7);
      keystroke = 12'h001;
      tick(7);
      if (i == 9) chk("t6_drop10", drop_cnt, 10);
      if (i == 254) chk("t6_drop255", drop_cnt, 255);
    end
    chk("t6_sat", drop_cnt, 255);
    chk("t6_still_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick(1);
    chk("t6_done", pending, 0);
    cmd_ready = 1'b0;
    tick(2);

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
